// File: rtl/if_stage_pkg.sv
// Shared constants for the fetch/decode pipeline: widths, special instruction
// words and the fetch FSM state encodings.
package if_stage_pkg;

    localparam int INSTR_W   = 16;
    localparam int ADDR_W    = 8;
    localparam int OPC_W     = 4;
    localparam int MEM_DEPTH = 256;

    localparam logic [OPC_W-1:0]   HALT_OPCODE = 4'hE;
    localparam logic [INSTR_W-1:0] NOP_INSTR   = 16'h0000;

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OPC_W] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/if_stage_instr_mem.sv
// 256 x 16 instruction store: synchronous write, asynchronous read.
// A read of the address being written returns the word stored before the edge.
module if_stage_instr_mem
    import if_stage_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [INSTR_W-1:0] rd_data
);

    logic [INSTR_W-1:0] mem [MEM_DEPTH];

    // No reset: program loads happen while the pipeline is held in reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, RUN/HALT control and the registered outputs
// handed to the IF/ID buffer.
module if_stage
    import if_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    output logic [INSTR_W-1:0] instruc_out,
    output logic [ADDR_W-1:0]  addr_out,
    output logic               valid_out,
    output logic               halted
);

    logic [ADDR_W-1:0]  pc;
    logic [0:0]         state;
    logic [INSTR_W-1:0] fetch_word;

    if_stage_instr_mem u_mem (
        .clk     (clk),
        .we      (prog_we),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_addr (pc),
        .rd_data (fetch_word)
    );

    // Priority: branch (also leaves HALT) > stall > normal fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= '0;
            state       <= RUN;
            instruc_out <= NOP_INSTR;
            addr_out    <= '0;
            valid_out   <= 1'b0;
            halted      <= 1'b0;
        end else if (branch_taken) begin
            pc          <= branch_addr;
            instruc_out <= NOP_INSTR;
            valid_out   <= 1'b0;
            state       <= RUN;
            halted      <= 1'b0;
        end else if (stall) begin
            pc          <= pc;
        end else if (state == RUN) begin
            instruc_out <= fetch_word;
            addr_out    <= pc;
            valid_out   <= 1'b1;
            if (is_halt(fetch_word)) begin
                state  <= HALT;
                halted <= 1'b1;
            end else begin
                pc <= pc + 8'd1;
            end
        end else begin
            instruc_out <= NOP_INSTR;
            valid_out   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: hand-derived expected outputs are queued
// when each cycle's stimulus is driven and compared after the clock edge.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_addr;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [15:0] prog_data;
    logic [15:0] instruc_out;
    logic [7:0]  addr_out;
    logic        valid_out;
    logic        halted;

    // {halted, valid_out, addr_out, instruc_out}
    logic [25:0] exp_q[$];
    int n_vec = 0;
    int n_mis = 0;
    logic [15:0] shadow [256];

    if_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .instruc_out  (instruc_out),
        .addr_out     (addr_out),
        .valid_out    (valid_out),
        .halted       (halted)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_vec(input string tag, input logic [25:0] obs, input logic [25:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got h=%0b v=%0b addr=%h instr=%h, want h=%0b v=%0b addr=%h instr=%h",
                     tag, obs[25], obs[24], obs[23:16], obs[15:0],
                     exp[25], exp[24], exp[23:16], exp[15:0]);
        end
    endtask

    function automatic logic [25:0] obs_vec();
        return {halted, valid_out, addr_out, instruc_out};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic load(input logic [7:0] a, input logic [15:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        shadow[a] = d;
        @(posedge clk);
        #1;
        prog_we = 1'b0;
    endtask

    // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
    task automatic step(input string tag, input logic s, input logic b, input logic [7:0] ba,
                        input logic [15:0] ei, input logic [7:0] ea, input logic ev, input logic eh);
        logic [25:0] exp;
        stall        = s;
        branch_taken = b;
        branch_addr  = ba;
        exp_q.push_back({eh, ev, ea, ei});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            exp = exp_q.pop_front();
            check_vec(tag, obs_vec(), exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0]  rpc;
        logic [25:0] last;
        int fetched;

        reset = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_addr = 8'h00;
        prog_we = 1'b0;
        prog_addr = 8'h00;
        prog_data = 16'h0000;

        @(posedge clk);
        #1;
        load(8'h00, 16'h1234);
        load(8'h01, 16'hF120);
        load(8'h02, 16'hDDDD);
        load(8'h03, 16'h3333);
        load(8'h05, 16'hE000);
        load(8'h10, 16'h0A0A);
        load(8'h11, 16'h0B0B);
        load(8'h40, 16'h5A5A);
        load(8'h41, 16'h6B6B);
        check_vec("reset_state", obs_vec(), {1'b0, 1'b0, 8'h00, 16'h0000});

        reset = 1'b0;
        step("seq0",        0, 0, 8'h00, 16'h1234, 8'h00, 1, 0);
        step("seq1",        0, 0, 8'h00, 16'hF120, 8'h01, 1, 0);
        step("stall0",      1, 0, 8'h00, 16'hF120, 8'h01, 1, 0);
        step("stall1",      1, 0, 8'h00, 16'hF120, 8'h01, 1, 0);
        step("seq2",        0, 0, 8'h00, 16'hDDDD, 8'h02, 1, 0);
        step("br40_flush",  0, 1, 8'h40, 16'h0000, 8'h02, 0, 0);
        step("br40_fetch",  0, 0, 8'h00, 16'h5A5A, 8'h40, 1, 0);
        step("brstl_flush", 1, 1, 8'h40, 16'h0000, 8'h40, 0, 0);
        step("brstl_fetch", 0, 0, 8'h00, 16'h5A5A, 8'h40, 1, 0);
        step("seq41",       0, 0, 8'h00, 16'h6B6B, 8'h41, 1, 0);
        step("br05_flush",  0, 1, 8'h05, 16'h0000, 8'h41, 0, 0);
        step("halt_instr",  0, 0, 8'h00, 16'hE000, 8'h05, 1, 1);
        step("halt_nop0",   0, 0, 8'h00, 16'h0000, 8'h05, 0, 1);
        step("halt_nop1",   0, 0, 8'h00, 16'h0000, 8'h05, 0, 1);
        step("halt_stall",  1, 0, 8'h00, 16'h0000, 8'h05, 0, 1);
        step("halt_br10",   0, 1, 8'h10, 16'h0000, 8'h05, 0, 0);
        step("resume10",    0, 0, 8'h00, 16'h0A0A, 8'h10, 1, 0);
        step("resume11",    0, 0, 8'h00, 16'h0B0B, 8'h11, 1, 0);

        // Mid-cycle reset must clear outputs without waiting for a clock edge.
        #2;
        reset = 1'b1;
        #1;
        check_vec("async_reset", obs_vec(), {1'b0, 1'b0, 8'h00, 16'h0000});
        @(posedge clk);
        #1;
        load(8'hFF, 16'h1111);
        load(8'h00, 16'h2222);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        // The edge above was the first after release, so re-align expectations.
        check_vec("restart00", obs_vec(), {1'b0, 1'b1, 8'h00, 16'h2222});
        step("brFF_flush",  0, 1, 8'hFF, 16'h0000, 8'h00, 0, 0);
        step("wrapFF",      0, 0, 8'h00, 16'h1111, 8'hFF, 1, 0);
        step("wrap00",      0, 0, 8'h00, 16'h2222, 8'h00, 1, 0);

        // Random stall pattern over the known words at 01..03.
        rpc = 8'h01;
        last = {1'b0, 1'b1, 8'h00, 16'h2222};
        fetched = 0;
        for (int i = 0; i < 40 && fetched < 3; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                step("rand_stall", 1, 0, 8'h00, last[15:0], last[23:16], last[24], last[25]);
            end else begin
                last = {1'b0, 1'b1, rpc, shadow[rpc]};
                step("rand_fetch", 0, 0, 8'h00, last[15:0], last[23:16], 1'b1, 1'b0);
                rpc = rpc + 8'd1;
                fetched++;
            end
        end
        if (fetched < 3) begin
            n_vec++;
            n_mis++;
            $display("FAIL rand_budget: fetched %0d words, want 3", fetched);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
